// File: rtl/phy_tx_arbiter_pkg.sv
// Shared definitions for the PHY transmit arbiter and its neighbours.
//   COMMA_DEFAULT : idle/comma byte sent during link bring-up and idle slots
//   NUM_LANES     : number of requesting lanes sharing the transmit slot
//   state_t       : link bring-up FSM states (SYNC sends commas, ACTIVE sends payload)
package phy_tx_arbiter_pkg;

  localparam logic [7:0]  COMMA_DEFAULT = 8'hBC;
  localparam int unsigned NUM_LANES     = 4;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/phy_tx_arbiter_if.sv
// Lane/serializer-facing signal bundle of phy_tx_arbiter.
//   data_in_0..3 / valid_in_0..3 : lane payload and request
//   ready_out_0..3               : lane byte accepted this cycle
//   tx_en, resync                : serializer slot strobe, comma-sequence restart
//   data_out, valid_out, grant   : byte to serializer, payload flag, source lane
//   link_up                      : link is in ACTIVE
// master: the side driving lanes/strobes; slave: the arbiter.
interface phy_tx_arbiter_if;

  logic [7:0] data_in_0;
  logic [7:0] data_in_1;
  logic [7:0] data_in_2;
  logic [7:0] data_in_3;
  logic       valid_in_0;
  logic       valid_in_1;
  logic       valid_in_2;
  logic       valid_in_3;
  logic       ready_out_0;
  logic       ready_out_1;
  logic       ready_out_2;
  logic       ready_out_3;
  logic       tx_en;
  logic       resync;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] grant;
  logic       link_up;

  modport master (
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3,
    output tx_en, resync,
    input  ready_out_0, ready_out_1, ready_out_2, ready_out_3,
    input  data_out, valid_out, grant, link_up
  );

  modport slave (
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  valid_in_0, valid_in_1, valid_in_2, valid_in_3,
    input  tx_en, resync,
    output ready_out_0, ready_out_1, ready_out_2, ready_out_3,
    output data_out, valid_out, grant, link_up
  );

endinterface

// File: rtl/phy_tx_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
//   req    : request vector, bit i = lane i
//   rr_ptr : lane with highest priority this cycle
//   found  : at least one request present
//   winner : first requesting lane searching upward from rr_ptr, modulo 4
module rr_pick4
  import phy_tx_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  lane_idx_t  rr_ptr,
  output logic       found,
  output lane_idx_t  winner
);

  lane_idx_t idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      // 2-bit add wraps the search back to lane 0
      idx = rr_ptr + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/phy_tx_arbiter.sv
// phy_tx_arbiter: round-robin scheduler sharing one byte-wide PHY transmit
// slot among four lanes, preceded by a comma-based link bring-up sequence.
//   clk_f   : clock, rising edge
//   reset_L : asynchronous active-low reset
//   bus     : lane inputs, ready strobes, tx_en/resync and registered
//             data_out/valid_out/grant/link_up (see phy_tx_arbiter_if)
// Parameters: SYNC_COMMAS (1..15) commas before link-up, COMMA idle byte.
module phy_tx_arbiter
  import phy_tx_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_COMMAS = 4,
  parameter logic [7:0]  COMMA       = COMMA_DEFAULT
) (
  input  logic             clk_f,
  input  logic             reset_L,
  phy_tx_arbiter_if.slave  bus
);

  localparam logic [3:0] LAST_COMMA = 4'(SYNC_COMMAS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] sync_cnt;
  lane_idx_t  rr_ptr;
  logic [3:0] req;
  logic       found;
  lane_idx_t  winner;
  logic       accept;
  logic [3:0] rdy;
  logic [7:0] sel_data;

  logic [7:0] data_q;
  logic       valid_q;
  lane_idx_t  grant_q;

  assign req = {bus.valid_in_3, bus.valid_in_2, bus.valid_in_1, bus.valid_in_0};

  rr_pick4 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (found),
    .winner (winner)
  );

  // State register
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) state <= ST_SYNC;
    else          state <= state_nxt;
  end

  // Next state: resync wins over everything, including the last comma
  always_comb begin
    state_nxt = state;
    if (bus.resync)
      state_nxt = ST_SYNC;
    else if (bus.tx_en && (state == ST_SYNC) && (sync_cnt == LAST_COMMA))
      state_nxt = ST_ACTIVE;
  end

  // Outputs: lane handshake and selected payload
  always_comb begin
    accept   = (state == ST_ACTIVE) && bus.tx_en && !bus.resync && found;
    rdy      = accept ? (4'b0001 << winner) : '0;
    sel_data = '0;
    case (winner)
      2'd0:    sel_data = bus.data_in_0;
      2'd1:    sel_data = bus.data_in_1;
      2'd2:    sel_data = bus.data_in_2;
      default: sel_data = bus.data_in_3;
    endcase
  end

  assign bus.ready_out_0 = rdy[0];
  assign bus.ready_out_1 = rdy[1];
  assign bus.ready_out_2 = rdy[2];
  assign bus.ready_out_3 = rdy[3];

  // Datapath registers: only tx_en or resync cycles move anything
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      data_q   <= COMMA;
      valid_q  <= 1'b0;
      grant_q  <= '0;
      rr_ptr   <= '0;
      sync_cnt <= '0;
    end else if (bus.resync) begin
      data_q   <= COMMA;
      valid_q  <= 1'b0;
      sync_cnt <= '0;
    end else if (bus.tx_en) begin
      if (state == ST_SYNC) begin
        data_q   <= COMMA;
        valid_q  <= 1'b0;
        sync_cnt <= sync_cnt + 4'd1;
      end else if (accept) begin
        data_q  <= sel_data;
        valid_q <= 1'b1;
        grant_q <= winner;
        rr_ptr  <= winner + 2'd1;
      end else begin
        data_q  <= COMMA;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.grant     = grant_q;
  // The state register itself is the registered link indication
  assign bus.link_up   = (state == ST_ACTIVE);

endmodule
